// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state type, default parameters and counter sizing for reset_sequencer
package reset_seq_pkg;

    typedef enum logic [2:0] {
        SYNC,
        WAIT,
        RELEASE,
        ACK_WAIT,
        SW_HOLD,
        DONE
    } seq_state_t;

    localparam int DEF_NUM_DOMAINS = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STEP_DELAY  = 16;
    localparam int DEF_HOLD_CYCLES = 8;
    localparam int DEF_ACK_TIMEOUT = 64;

    // One shared counter serves every timed state, so it is sized for the
    // longest interval; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - reset sequencer control/status bundle
// Signals: sw_rst_req (request in), rst_n_out/seq_done/busy (status out);
// domain_ack/ack_err only when RST_SEQ_ACK_EN is defined.
// master: the sequencer; slave: the consumer of the domain resets.
interface reset_sequencer_if
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS
);
    logic                   sw_rst_req;
    logic [NUM_DOMAINS-1:0] rst_n_out;
    logic                   seq_done;
    logic                   busy;
`ifdef RST_SEQ_ACK_EN
    logic [NUM_DOMAINS-1:0] domain_ack;
    logic                   ack_err;

    modport master (input sw_rst_req, input domain_ack,
                    output rst_n_out, output seq_done, output busy, output ack_err);
    modport slave  (output sw_rst_req, output domain_ack,
                    input rst_n_out, input seq_done, input busy, input ack_err);
`else
    modport master (input sw_rst_req,
                    output rst_n_out, output seq_done, output busy);
    modport slave  (output sw_rst_req,
                    input rst_n_out, input seq_done, input busy);
`endif
endinterface

// File: rtl/reset_sync_core.sv
// rtl/reset_sync_core.sv - board reset synchronizer: asserts asynchronously, releases on a clock edge
// Ports: clk, rst (async active-low), sync_rst_n (synchronized, high after SYNC_STAGES edges).
module reset_sync_core
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    output logic sync_rst_n
);
    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_rst_n = ff[SYNC_STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered, timed release of per-domain resets with software re-sequencing
// Ports: clk, rst (async active-low board reset), bus (reset_sequencer_if.master):
//   sw_rst_req in, rst_n_out/seq_done/busy out; domain_ack in / ack_err out with RST_SEQ_ACK_EN.
// Optional feature macro: RST_SEQ_ACK_EN (per-domain acknowledge with timeout).
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STEP_DELAY  = DEF_STEP_DELAY,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    reset_sequencer_if.master bus
);
    localparam int CW = cnt_width(STEP_DELAY, HOLD_CYCLES, ACK_TIMEOUT);
    localparam int IW = $clog2(NUM_DOMAINS + 1);

    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_DELAY - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DOMAINS);

    seq_state_t             state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt, cnt_inc;
    logic [IW-1:0]          idx, idx_nxt;
    logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_nxt;
    logic                   sync_rst_n;
    logic                   do_release;

    reset_sync_core #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .sync_rst_n (sync_rst_n)
    );

`ifdef RST_SEQ_ACK_EN
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);

    logic ack_sel, ack_q, ack_err_q, ack_err_set;

    // idx already points past the domain just released, so its ack is idx-1.
    always_comb begin
        ack_sel = 1'b0;
        for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (idx == IW'(k + 1)) ack_sel = bus.domain_ack[k];
        end
    end

    // Registering the ack makes the next step count begin on the edge after
    // the ack is sampled, and keeps the external ack off the FSM decode path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q     <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            ack_q <= ack_sel;
            if (ack_err_set) ack_err_q <= 1'b1;
        end
    end

    assign bus.ack_err = ack_err_q;
`endif

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SYNC;
            cnt     <= '0;
            idx     <= '0;
            rst_n_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            rst_n_q <= rst_n_nxt;
        end
    end

    // cnt counts edges since the current interval began; an interval of N
    // ends on the edge that sees N-1. Entering WAIT from SYNC loads 1 because
    // the first step interval is measured from the synchronizer release edge.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        rst_n_nxt  = rst_n_q;
        do_release = 1'b0;
`ifdef RST_SEQ_ACK_EN
        ack_err_set = 1'b0;
`endif
        case (state)
            SYNC: begin
                if (sync_rst_n) begin
                    if (cnt == STEP_LAST) begin
                        do_release = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            WAIT: begin
                if (cnt == STEP_LAST) do_release = 1'b1;
                else                  cnt_nxt    = cnt_inc;
            end
            RELEASE: begin
`ifdef RST_SEQ_ACK_EN
                state_nxt = ACK_WAIT;
                cnt_nxt   = cnt_inc;
`else
                // RELEASE is the first edge of the next step interval.
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else if (cnt == STEP_LAST) begin
                    do_release = 1'b1;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = cnt_inc;
                end
`endif
            end
`ifdef RST_SEQ_ACK_EN
            ACK_WAIT: begin
                if (ack_q || cnt == ACK_LAST) begin
                    ack_err_set = !ack_q;
                    state_nxt   = (idx == LAST_IDX) ? DONE : WAIT;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
`endif
            SW_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = SYNC;
        endcase

        if (do_release) begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
            idx_nxt   = idx + IW'(1);
            for (int k = 0; k < NUM_DOMAINS; k++) begin
                if (idx == IW'(k)) rst_n_nxt[k] = 1'b1;
            end
        end

        // Software request wins over everything except the board-reset sync;
        // inside SW_HOLD it simply restarts the hold interval.
        if (bus.sw_rst_req && state != SYNC) begin
            state_nxt = SW_HOLD;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            rst_n_nxt = '0;
        end
    end

    assign bus.rst_n_out = rst_n_q;
    assign bus.seq_done  = (state == DONE);
    assign bus.busy      = (state != DONE);
endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   edge_cnt = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    reset_sequencer_if #(.NUM_DOMAINS(4)) bus ();

    reset_sequencer #(
        .NUM_DOMAINS (4),
        .SYNC_STAGES (2),
        .STEP_DELAY  (16),
        .HOLD_CYCLES (8),
        .ACK_TIMEOUT (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_no;
        logic       sw_after;
        logic [3:0] rst_n;
        logic       done;
        logic       busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] rn, input logic d, input logic b);
        check({tag, " rst_n_out"}, 32'(bus.rst_n_out), 32'(rn));
        check({tag, " seq_done"},  32'(bus.seq_done),  32'(d));
        check({tag, " busy"},      32'(bus.busy),      32'(b));
    endtask

    // Advance to edge n (edge 1 = first rising edge with rst high), sample 1ns after.
    task automatic step_to(input int n);
        while (edge_cnt < n) begin
            @(posedge clk);
            edge_cnt++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.sw_rst_req = 1'b0;
`ifdef RST_SEQ_ACK_EN
        bus.domain_ack = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 4'b0000, 1'b0, 1'b1);
`ifdef RST_SEQ_ACK_EN
        check("reset ack_err", 32'(bus.ack_err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        edge_cnt = 0;
    endtask

`ifndef RST_SEQ_ACK_EN
    localparam int NV = 24;
    vec_t vecs [0:NV-1];
`endif

    initial begin
        bus.sw_rst_req = 1'b0;
`ifndef RST_SEQ_ACK_EN
        // Power-on sequence, single-cycle sw request in DONE, then a 5-cycle
        // request that extends the hold (sampled high at edges 201..205).
        vecs[0]  = '{1,   1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[1]  = '{2,   1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[2]  = '{17,  1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[3]  = '{18,  1'b0, 4'b0001, 1'b0, 1'b1};
        vecs[4]  = '{33,  1'b0, 4'b0001, 1'b0, 1'b1};
        vecs[5]  = '{34,  1'b0, 4'b0011, 1'b0, 1'b1};
        vecs[6]  = '{50,  1'b0, 4'b0111, 1'b0, 1'b1};
        vecs[7]  = '{65,  1'b0, 4'b0111, 1'b0, 1'b1};
        vecs[8]  = '{66,  1'b0, 4'b1111, 1'b0, 1'b1};
        vecs[9]  = '{67,  1'b0, 4'b1111, 1'b1, 1'b0};
        vecs[10] = '{100, 1'b1, 4'b1111, 1'b1, 1'b0};
        vecs[11] = '{101, 1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[12] = '{124, 1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[13] = '{125, 1'b0, 4'b0001, 1'b0, 1'b1};
        vecs[14] = '{141, 1'b0, 4'b0011, 1'b0, 1'b1};
        vecs[15] = '{173, 1'b0, 4'b1111, 1'b0, 1'b1};
        vecs[16] = '{174, 1'b0, 4'b1111, 1'b1, 1'b0};
        vecs[17] = '{200, 1'b1, 4'b1111, 1'b1, 1'b0};
        vecs[18] = '{201, 1'b1, 4'b0000, 1'b0, 1'b1};
        vecs[19] = '{205, 1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[20] = '{225, 1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[21] = '{228, 1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[22] = '{229, 1'b0, 4'b0001, 1'b0, 1'b1};
        vecs[23] = '{245, 1'b0, 4'b0011, 1'b0, 1'b1};

        do_reset();
        for (int i = 0; i < NV; i++) begin
            step_to(vecs[i].edge_no);
            check_outs($sformatf("vec%0d edge%0d", i, vecs[i].edge_no),
                       vecs[i].rst_n, vecs[i].done, vecs[i].busy);
            bus.sw_rst_req = vecs[i].sw_after;
        end

        // Board reset pulsed mid-sequence: outputs clear with no clock edge,
        // and a sw request during SYNC is ignored.
        do_reset();
        step_to(40);
        check_outs("pre-pulse e40", 4'b0011, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        check_outs("async clear", 4'b0000, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        edge_cnt = 0;
        bus.sw_rst_req = 1'b1;
        step_to(2);
        bus.sw_rst_req = 1'b0;
        check_outs("restart e2", 4'b0000, 1'b0, 1'b1);
        step_to(17);
        check_outs("restart e17", 4'b0000, 1'b0, 1'b1);
        step_to(18);
        check_outs("restart e18", 4'b0001, 1'b0, 1'b1);
`else
        // Each ack sampled 3 edges after its release: releases 20 edges apart.
        do_reset();
        step_to(18);  check_outs("ackA e18", 4'b0001, 1'b0, 1'b1);
        step_to(20);  bus.domain_ack = 4'b0001;
        step_to(37);  check_outs("ackA e37", 4'b0001, 1'b0, 1'b1);
        step_to(38);  check_outs("ackA e38", 4'b0011, 1'b0, 1'b1);
        step_to(40);  bus.domain_ack = 4'b0011;
        step_to(58);  check_outs("ackA e58", 4'b0111, 1'b0, 1'b1);
        step_to(60);  bus.domain_ack = 4'b0111;
        step_to(78);  check_outs("ackA e78", 4'b1111, 1'b0, 1'b1);
        step_to(80);  bus.domain_ack = 4'b1111;
        step_to(81);  check_outs("ackA e81", 4'b1111, 1'b0, 1'b1);
        step_to(82);  check_outs("ackA e82", 4'b1111, 1'b1, 1'b0);
        check("ackA ack_err", 32'(bus.ack_err), 32'd0);

        // domain_ack[1] never arrives: timeout 64 edges after release at 38.
        do_reset();
        step_to(18);  check_outs("ackB e18", 4'b0001, 1'b0, 1'b1);
        step_to(20);  bus.domain_ack = 4'b0001;
        step_to(38);  check_outs("ackB e38", 4'b0011, 1'b0, 1'b1);
        step_to(101); check("ackB e101 ack_err", 32'(bus.ack_err), 32'd0);
        step_to(102); check("ackB e102 ack_err", 32'(bus.ack_err), 32'd1);
        step_to(117); check_outs("ackB e117", 4'b0011, 1'b0, 1'b1);
        step_to(118); check_outs("ackB e118", 4'b0111, 1'b0, 1'b1);
        step_to(120); bus.domain_ack = 4'b0101;
        step_to(137); check_outs("ackB e137", 4'b0111, 1'b0, 1'b1);
        step_to(138); check_outs("ackB e138", 4'b1111, 1'b0, 1'b1);
        check("ackB sticky ack_err", 32'(bus.ack_err), 32'd1);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
